// File: rtl/cpu_trace_buffer.sv
// CPU trace capture: writeback/IR events plus one halt/fault record, drained over valid/ready. Optional macro: TRACE_IR_EN.
// Latency: an event sampled at edge N is at the head after edge N when the FIFO was empty.
// Backpressure: a full FIFO drops normal records (sticky overflow, drop_cnt); the terminal record waits for a slot.
module cpu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CP,
    input  logic          reset,
    input  logic          arm,
    input  logic          writePC,
    input  logic          writeIR,
    input  logic          writeReg,
    input  logic [31:0]   F,
    input  logic [31:0]   IR,
    input  logic [7:0]    PC,
    input  logic [3:0]    nzcv,
    input  logic          done,
    input  logic          err,
    output logic          tr_valid,
    input  logic          tr_ready,
    output logic [45:0]   tr_data,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    output logic [15:0]   evt_cnt,
    output logic          halted
);

    typedef enum logic [1:0] {IDLE, RUN, TERM, HALTED} state_t;

    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    state_t      state;
    logic [45:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [45:0] term_rec;

    logic        full;
    logic        pop;
    logic        in_run;
    logic        norm_vld;
    logic [45:0] norm_rec;
    logic        ir_conflict;
    logic        term_push;
    logic        push_ok;
    logic        push_drop;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;
    logic [45:0] push_rec;

    assign count    = wr_ptr - rd_ptr;
    assign tr_valid = (count != '0);
    assign tr_data  = mem[rd_ptr[AW-1:0]];
    assign full     = (count == DEPTH_CNT);
    assign pop      = tr_valid & tr_ready;
    assign in_run   = (state == RUN);

`ifdef TRACE_IR_EN
    // A simultaneous register write takes the slot; the IR event is lost and counted.
    always_comb begin
        norm_vld    = in_run & (writeReg | writeIR);
        ir_conflict = in_run & writeReg & writeIR;
        if (writeReg)
            norm_rec = {2'd0, PC, nzcv, F};
        else
            norm_rec = {2'd1, PC, nzcv, IR};
    end
`else
    logic unused_ir;
    assign unused_ir = ^{writeIR, IR};

    always_comb begin
        norm_vld    = in_run & writeReg;
        ir_conflict = 1'b0;
        norm_rec    = {2'd0, PC, nzcv, F};
    end
`endif

    assign term_push = (state == TERM) & (~full | pop);
    assign push_ok   = (norm_vld | term_push) & (~full | pop);
    assign push_drop = norm_vld & full & ~pop;
    assign push_rec  = term_push ? term_rec : norm_rec;
    assign drop_inc  = {1'b0, push_drop} + {1'b0, ir_conflict};
    assign drop_sum  = {1'b0, drop_cnt} + {7'd0, drop_inc};

    always_ff @(posedge CP) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= push_rec;
    end

    always_ff @(posedge CP) begin
        if (!reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            term_rec <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            evt_cnt  <= '0;
            halted   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (drop_inc != 2'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
            if (in_run && writePC)
                evt_cnt <= evt_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (arm)
                        state <= RUN;
                end
                RUN: begin
                    // Halt/fault takes priority over disarm in the same cycle.
                    if (done || err) begin
                        state    <= TERM;
                        term_rec <= {(err ? 2'd3 : 2'd2), PC, nzcv, 32'd0};
                    end else if (!arm) begin
                        state <= IDLE;
                    end
                end
                TERM: begin
                    if (term_push) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: records are queued as stimulus is driven and compared as they drain.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        CP = 1'b0;
    logic        reset, arm, writePC, writeIR, writeReg, done, err, tr_ready;
    logic [31:0] F, IR;
    logic [7:0]  PC;
    logic [3:0]  nzcv;
    logic        tr_valid, overflow, halted;
    logic [45:0] tr_data;
    logic [AW:0] count;
    logic [7:0]  drop_cnt;
    logic [15:0] evt_cnt;

    int checks   = 0;
    int failures = 0;
    int model_drops = 0;
    logic [45:0] exp_q [$];
    logic [45:0] term;

    cpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CP(CP), .reset(reset), .arm(arm), .writePC(writePC), .writeIR(writeIR),
        .writeReg(writeReg), .F(F), .IR(IR), .PC(PC), .nzcv(nzcv), .done(done),
        .err(err), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .evt_cnt(evt_cnt),
        .halted(halted)
    );

    always #5 CP = ~CP;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    function automatic logic [45:0] rec(input logic [1:0] k, input logic [7:0] p,
                                        input logic [3:0] n, input logic [31:0] d);
        return {k, p, n, d};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        arm   = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        model_drops = 0;
    endtask

    task automatic check_head(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s got=valid_data exp=no_record", tag);
        end else begin
            chk({tag, "_vld"}, tr_valid, 1'b1);
            chk({tag, "_dat"}, tr_data, exp_q.pop_front());
        end
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        tr_ready = 1'b1;
        tick();
        tr_ready = 1'b0;
    endtask

    // Drive one register-write event, optionally with a pop in the same cycle.
    task automatic push_reg(input logic [31:0] f, input logic [7:0] p, input logic [3:0] n,
                            input bit pop_too);
        if (pop_too && exp_q.size() > 0)
            check_head("pop_with_push");
        if (exp_q.size() < DEPTH)
            exp_q.push_back(rec(2'd0, p, n, f));
        else
            model_drops++;
        F = f; PC = p; nzcv = n;
        writeReg = 1'b1;
        tr_ready = pop_too;
        tick();
        writeReg = 1'b0;
        tr_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; writePC = 1'b0; writeIR = 1'b0; writeReg = 1'b0;
        done = 1'b0; err = 1'b0; tr_ready = 1'b0;
        F = '0; IR = '0; PC = '0; nzcv = '0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_valid", tr_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_evt", evt_cnt, 0);
        chk("rst_halted", halted, 1'b0);

        // IDLE captures nothing
        writeReg = 1'b1; writePC = 1'b1; F = 32'd5;
        tick();
        writeReg = 1'b0; writePC = 1'b0;
        chk("idle_count", count, 0);
        chk("idle_evt", evt_cnt, 0);

        arm = 1'b1;
        tick();
        push_reg(32'h0000_002A, 8'h04, 4'b0100, 1'b0);
        chk("lat_count", count, 1);
        chk("lat_valid", tr_valid, 1'b1);
        chk("lat_data", tr_data, {2'd0, 8'h04, 4'h4, 32'h0000_002A});
        pop_one("first");
        chk("pop_valid", tr_valid, 1'b0);
        chk("pop_count", count, 0);

        for (int i = 0; i < 3; i++) begin
            writePC = 1'b1;
            tick();
        end
        writePC = 1'b0;
        chk("evt_run", evt_cnt, 3);

        // push with ready while empty: record lands, pop ignored
        push_reg(32'h77, 8'h11, 4'h1, 1'b1);
        chk("empty_pushpop_count", count, 1);
        pop_one("empty_pushpop");

        arm = 1'b0;
        tick();
        writeReg = 1'b1;
        tick();
        writeReg = 1'b0;
        chk("disarm_count", count, 0);
        arm = 1'b1;
        tick();

        for (int i = 1; i <= 18; i++)
            push_reg(32'(i), 8'(i), 4'(i), 1'b0);
        chk("fill_count", count, DEPTH);
        chk("fill_ovf", overflow, model_drops > 0);
        chk("fill_drop", drop_cnt, model_drops);

        push_reg(32'h99, 8'h99, 4'h9, 1'b1);
        chk("full_pushpop_count", count, DEPTH);
        chk("full_pushpop_drop", drop_cnt, model_drops);

        PC = 8'hA0; nzcv = 4'hA; done = 1'b1;
        tick();
        done = 1'b0;
        term = rec(2'd2, 8'hA0, 4'hA, 32'd0);
        chk("term_halted", halted, 1'b0);
        chk("term_count", count, DEPTH);

        writeReg = 1'b1;
        tick();
        tick();
        writeReg = 1'b0;
        chk("term_wait_count", count, DEPTH);
        chk("term_wait_drop", drop_cnt, model_drops);
        chk("term_wait_halted", halted, 1'b0);

        pop_one("term_pop");
        exp_q.push_back(term);
        chk("halt_halted", halted, 1'b1);
        chk("halt_count", count, DEPTH);

        writeReg = 1'b1; arm = 1'b0;
        tick();
        writeReg = 1'b0;
        tick();
        chk("halted_stays", halted, 1'b1);
        chk("halted_count", count, DEPTH);

        for (int i = 0; i < DEPTH; i++)
            pop_one("drain");
        chk("drain_count", count, 0);
        chk("drain_valid", tr_valid, 1'b0);

        do_reset();
        chk("rst2_ovf", overflow, 1'b0);
        chk("rst2_drop", drop_cnt, 0);
        chk("rst2_halted", halted, 1'b0);

        // done and err together: fault record wins
        arm = 1'b1;
        tick();
        PC = 8'h10; nzcv = 4'h3; done = 1'b1; err = 1'b1;
        tick();
        done = 1'b0; err = 1'b0;
        chk("fault_pending_halted", halted, 1'b0);
        chk("fault_pending_count", count, 0);
        tick();
        chk("fault_halted", halted, 1'b1);
        chk("fault_count", count, 1);
        chk("fault_data", tr_data, {2'd3, 8'h10, 4'h3, 32'd0});

        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        chk("midrst_count", count, 0);
        chk("midrst_valid", tr_valid, 1'b0);
        chk("midrst_halted", halted, 1'b0);
        chk("midrst_ovf", overflow, 1'b0);

        arm = 1'b1;
        tick();
        IR = 32'hE3A0_0001; PC = 8'h00; nzcv = 4'h0; writeIR = 1'b1;
        tick();
        writeIR = 1'b0;
`ifdef TRACE_IR_EN
        exp_q.push_back(rec(2'd1, 8'h00, 4'h0, 32'hE3A0_0001));
        chk("ir_count", count, 1);
        pop_one("ir_rec");
        writeIR = 1'b1;
        push_reg(32'h33, 8'h01, 4'h2, 1'b0);
        writeIR = 1'b0;
        chk("ir_conflict_count", count, 1);
        chk("ir_conflict_drop", drop_cnt, 1);
        chk("ir_conflict_ovf", overflow, 1'b1);
`else
        chk("ir_ignored_count", count, 0);
        writeIR = 1'b1;
        push_reg(32'h33, 8'h01, 4'h2, 1'b0);
        writeIR = 1'b0;
        chk("ir_both_count", count, 1);
        chk("ir_both_drop", drop_cnt, 0);
`endif
        pop_one("ir_reg");
        chk("end_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Passive consumer of the CPU_Top debug outputs (writePC, writeIR, writeReg, F, IR, PC, nzcv, done, err).
- Captures register-writeback events into a record FIFO, appends one terminal record when the CPU halts or faults, and drains the records through a valid/ready stream.
- Sits beside CPU_Top in simulation and FPGA builds; it is the reader end of the CPU trace interface that CPU_Top drives.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2).
- AW, 4, pointer width = log2(DEPTH).

Ports:
- CP  in  1  clock; all state updates on posedge CP.
- reset  in  1  synchronous, active-low reset (reset=0 at posedge CP clears state).
- arm  in  1  level; 1 enables capture.
- writePC  in  1  CPU PC write strobe (not recorded; only counted in evt_cnt).
- writeIR  in  1  CPU IR write strobe.
- writeReg  in  1  CPU register write strobe.
- F  in  32  ALU/writeback result.
- IR  in  32  instruction register.
- PC  in  8  program counter.
- nzcv  in  4  flags.
- done  in  1  CPU halt.
- err  in  1  CPU fault.
- tr_valid  out  1  head record available.
- tr_ready  in  1  consumer accepts head.
- tr_data  out  46  {kind[45:44], PC[43:36], nzcv[35:32], data[31:0]}.
- count  out  AW+1  entries held.
- overflow  out  1  sticky; a record was dropped.
- drop_cnt  out  8  dropped records, saturating at 255.
- evt_cnt  out  16  writePC strobes seen while RUN, wraps.
- halted  out  1  state==HALTED.

Behaviour:
- Reset values:
  - tr_valid=0, count=0, overflow=0, drop_cnt=0, evt_cnt=0, halted=0.
  - Pointers=0, state=IDLE.
  - tr_data is don't-care while tr_valid=0.
- Record kinds:
  - 0 = register write (data=F).
  - 1 = IR load (data=IR).
  - 2 = done (data=0).
  - 3 = err (data=0).
  - PC and nzcv are sampled in the same cycle as the event.
- FSM:
  - IDLE: no capture. arm=1 → RUN.
  - RUN: capture events. arm=0 → IDLE. done|err sampled 1 → TERM; err wins kind=3 if both are high. Normal events in that same cycle are still pushed.
  - TERM: terminal record pending. Pushed on the first cycle with a free slot, and in the cycle the FIFO pops while full. After the push → HALTED.
  - HALTED: no capture. Leave only by reset; arm is ignored.
- Push rules:
  - Push when state==RUN and writeReg=1.
  - Maximum one push per cycle.
  - The terminal push in TERM uses that cycle's push slot.
- Latency: an event sampled at edge N gives tr_valid=1 and tr_data=record after edge N, provided the FIFO was empty.
- FIFO:
  - tr_valid = (count!=0).
  - tr_data = mem[rd_ptr]; pop on tr_valid&tr_ready.
  - Pointers wrap modulo DEPTH.
  - count = wr_ptr-rd_ptr with an extra MSB.
- Full FIFO:
  - A normal push with count==DEPTH and no simultaneous pop is dropped: overflow←1, drop_cnt+1 (saturating).
  - Push and pop in the same cycle while full: both take effect; count stays at DEPTH; no drop.
  - Push and pop in the same cycle while empty: the record is written; count stays 0→1−1 rules do not apply, so count becomes 1. Pop is ignored because tr_valid was 0.
- The terminal record is never dropped; it waits in TERM.
- tr_ready while empty has no effect.
- evt_cnt increments on writePC only in RUN.
- reset=0 mid-operation:
  - Discards all records and returns to IDLE on that edge.
  - tr_valid is 0 from the next cycle.

Optional Feature:
- Macro TRACE_IR_EN.
- Defined:
  - writeIR in RUN also pushes a kind-1 record.
  - If writeIR and writeReg are both high in the same cycle, the kind-0 record is pushed. The IR event counts as a drop: drop_cnt+1, overflow←1.
- Undefined:
  - writeIR is ignored.
  - Kind 1 is never produced.

Test Plan:
- Reset, arm=1, writeReg=1 for 1 cycle with PC=8'h04, nzcv=4'b0100, F=32'h0000_002A → next cycle tr_valid=1, tr_data=46'h0_04_4_0000002A, count=1. tr_ready=1 → tr_valid=0.
- tr_ready=0, 18 writeReg pulses with F=1..18, DEPTH=16 → count=16, overflow=1, drop_cnt=2. Draining yields F=1..16 in order.
- FIFO full, writeReg=1 and tr_ready=1 in the same cycle → count stays 16, drop_cnt unchanged, last record present.
- FIFO full, done=1 → state TERM, halted=0. Pop one → next cycle terminal kind=2 is written, halted=1. Further writeReg is ignored.
- done=1 and err=1 in the same cycle with an empty FIFO → one record with kind=3, halted=1 after the push. reset=0 one cycle → count=0, halted=0, overflow=0.
- With TRACE_IR_EN: writeIR alone with IR=32'hE3A0_0001, PC=8'h00 → kind=1 record. writeIR and writeReg together → only the kind-0 record, drop_cnt=1.
